// File: rtl/key_matcher.sv
// key_matcher: brute-force Hamming matcher for ORB keypoints.
// Each popped keypoint is scanned against the previous frame's reference bank
// and one match record is emitted. The current frame is stored into the other
// bank, and the two banks swap roles at frame end.
// Optional build macro: HAMMING_PIPE_EN registers the XOR/popcount result,
// which adds one cycle to every scan.
module key_matcher #(
  parameter int         SIZE   = 32,
  parameter logic [8:0] THRESH = 9'd64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_next,
  input  logic         i_frame_end,
  input  logic [9:0]   i_coor_x,
  input  logic [9:0]   i_coor_y,
  input  logic [255:0] i_descriptor,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [9:0]   o_cur_x,
  output logic [9:0]   o_cur_y,
  output logic [9:0]   o_ref_x,
  output logic [9:0]   o_ref_y,
  output logic [8:0]   o_dist,
  output logic         o_match,
  output logic         o_drop,
  output logic         o_frame_done
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int EW = 276;  // {x, y, descriptor}
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_e;

  function automatic logic [8:0] popcount(input logic [255:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < 256; i++) c = c + 9'(v[i]);
    return c;
  endfunction

  state_e          state_q, state_d;
  logic            bank_q, bank_d;
  logic [CW-1:0]   ref_cnt_q, ref_cnt_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   scan_q, scan_d;
  logic            drop_q, drop_d;
  logic            frame_done_q, frame_done_d;
  logic            swap_pend_q, swap_pend_d;
  logic [9:0]      qx_q, qx_d, qy_q, qy_d;
  logic [255:0]    qdesc_q, qdesc_d;
  logic [8:0]      best_dist_q, best_dist_d;
  logic [9:0]      best_x_q, best_x_d, best_y_q, best_y_d;

  logic [EW-1:0]   mem_q [2**(AW+1)];
  logic            wr_en;
  logic [AW:0]     wr_addr;
  logic [EW-1:0]   rd_entry;
  logic [8:0]      dist_c;
  logic            do_swap;

  // Compare-stage inputs: either the live popcount or its registered copy.
  logic            cmp_vld;
  logic [8:0]      cmp_dist;
  logic [9:0]      cmp_x, cmp_y;
  logic            scan_last;

  assign wr_addr  = {bank_q, wr_cnt_q[AW-1:0]};
  assign rd_entry = mem_q[{~bank_q, scan_q[AW-1:0]}];
  assign dist_c   = popcount(qdesc_q ^ rd_entry[255:0]);

`ifdef HAMMING_PIPE_EN
  logic       pvld_q;
  logic [8:0] pdist_q;
  logic [9:0] px_q, py_q;
  logic       issue;

  assign issue = (scan_q < ref_cnt_q);

  // Distance pipeline stage: carries each distance with its reference coords.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pvld_q  <= 1'b0;
      pdist_q <= 9'd256;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      pvld_q  <= (state_q == SCAN) && issue;
      pdist_q <= dist_c;
      px_q    <= rd_entry[275:266];
      py_q    <= rd_entry[265:256];
    end
  end

  assign cmp_vld   = (state_q == SCAN) && pvld_q;
  assign cmp_dist  = pdist_q;
  assign cmp_x     = px_q;
  assign cmp_y     = py_q;
  assign scan_last = (scan_q == ref_cnt_q);
`else
  assign cmp_vld   = (state_q == SCAN);
  assign cmp_dist  = dist_c;
  assign cmp_x     = rd_entry[275:266];
  assign cmp_y     = rd_entry[265:256];
  assign scan_last = ((scan_q + ONE_C) == ref_cnt_q);
`endif

  // Next-state logic for the FSM, counters, query latch and best match.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    bank_d       = bank_q;
    ref_cnt_d    = ref_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    scan_d       = scan_q;
    drop_d       = drop_q;
    frame_done_d = 1'b0;
    swap_pend_d  = swap_pend_q;
    qx_d         = qx_q;
    qy_d         = qy_q;
    qdesc_d      = qdesc_q;
    best_dist_d  = best_dist_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    wr_en        = 1'b0;
    do_swap      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          qx_d        = i_coor_x;
          qy_d        = i_coor_y;
          qdesc_d     = i_descriptor;
          best_dist_d = 9'd256;
          best_x_d    = '0;
          best_y_d    = '0;
          scan_d      = '0;
          swap_pend_d = i_frame_end;
          if (wr_cnt_q < SIZE_C) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + ONE_C;
          end else begin
            drop_d = 1'b1;
          end
          state_d = (ref_cnt_q != '0) ? SCAN : EMIT;
        end else if (i_frame_end) begin
          do_swap = 1'b1;
        end
      end
      SCAN: begin
        // Strict less-than keeps the lowest index on ties.
        if (cmp_vld && (cmp_dist < best_dist_q)) begin
          best_dist_d = cmp_dist;
          best_x_d    = cmp_x;
          best_y_d    = cmp_y;
        end
        scan_d = scan_q + ONE_C;
        if (scan_last) state_d = EMIT;
      end
      EMIT: begin
        if (i_ready) begin
          state_d = IDLE;
          if (swap_pend_q) begin
            do_swap     = 1'b1;
            swap_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_swap) begin
      bank_d       = ~bank_q;
      ref_cnt_d    = wr_cnt_q;
      wr_cnt_d     = '0;
      drop_d       = 1'b0;
      frame_done_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    if (!i_rst_n) begin
      state_q      <= IDLE;
      bank_q       <= 1'b0;
      ref_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      scan_q       <= '0;
      drop_q       <= 1'b0;
      frame_done_q <= 1'b0;
      swap_pend_q  <= 1'b0;
      qx_q         <= '0;
      qy_q         <= '0;
      qdesc_q      <= '0;
      best_dist_q  <= 9'd256;
      best_x_q     <= '0;
      best_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      ref_cnt_q    <= ref_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      scan_q       <= scan_d;
      drop_q       <= drop_d;
      frame_done_q <= frame_done_d;
      swap_pend_q  <= swap_pend_d;
      qx_q         <= qx_d;
      qy_q         <= qy_d;
      qdesc_q      <= qdesc_d;
      best_dist_q  <= best_dist_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
    end
  end

  // Ping-pong keypoint storage write port.
  always_ff @(posedge i_clk) begin
    // NOTE: storage has no reset; the counters define which entries are meaningful.
    if (wr_en) mem_q[wr_addr] <= {i_coor_x, i_coor_y, i_descriptor};
  end

  assign o_next       = (state_q == IDLE);
  assign o_valid      = (state_q == EMIT);
  assign o_match      = o_valid && (ref_cnt_q != '0) && (best_dist_q <= THRESH);
  assign o_dist       = best_dist_q;
  assign o_cur_x      = qx_q;
  assign o_cur_y      = qy_q;
  assign o_ref_x      = best_x_q;
  assign o_ref_y      = best_y_q;
  assign o_drop       = drop_q;
  assign o_frame_done = frame_done_q;

endmodule
